// File: rtl/multi_steer_quad.sv
// N-channel left/right to quadrature steering encoder with a shared prescaler,
// hold-to-accelerate step-rate ramping and a one-cycle strobe per step.
module multi_steer_quad #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned SLOW     = 4,
  parameter int unsigned FAST     = 1,
  parameter int unsigned RAMP     = 8
) (
  input  logic                  CLK,
  input  logic                  Reset_n,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  enable,
  input  logic                  accel_en,
  input  logic [CHANNELS-1:0]   left,
  input  logic [CHANNELS-1:0]   right,
  output logic [2*CHANNELS-1:0] steer,
  output logic [CHANNELS-1:0]   step_strobe
);

  localparam int unsigned PER_W  = 8;
  localparam int unsigned RAMP_W = (RAMP > 1) ? $clog2(RAMP + 1) : 1;

  logic [DIV_W-1:0] pre_q;
  logic [DIV_W-1:0] pre_d;
  logic [DIV_W-1:0] div_m1;
  logic             tick;

  // Shared prescaler; a divisor of 0 behaves as 1 (tick every cycle).
  always_comb begin
    div_m1 = (clkdiv == '0) ? '0 : clkdiv - DIV_W'(1);
    tick   = enable && (pre_q >= div_m1);
    pre_d  = pre_q;
    if (tick) begin
      pre_d = '0;
    end else if (enable) begin
      pre_d = pre_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]        phase_q;
    logic [1:0]        phase_d;
    logic [PER_W-1:0]  ival_q;
    logic [PER_W-1:0]  ival_d;
    logic [PER_W-1:0]  per_q;
    logic [PER_W-1:0]  per_d;
    logic [RAMP_W-1:0] ramp_q;
    logic [RAMP_W-1:0] ramp_d;
    logic              last_r_q;
    logic              last_l_q;
    logic              step_d;
    logic [1:0]        steer_q;
    logic              strobe_q;
    logic              mv_r;
    logic              mv_l;
    logic              flush;

    assign mv_r  = right[g] & ~left[g];
    assign mv_l  = left[g] & ~right[g];
    // Idle and an immediate direction reversal both restart the rate ramp.
    assign flush = ~(mv_r | mv_l) | (mv_r & last_l_q) | (mv_l & last_r_q);

    always_comb begin
      phase_d = phase_q;
      ival_d  = ival_q;
      per_d   = per_q;
      ramp_d  = ramp_q;
      step_d  = 1'b0;
      if (flush) begin
        ival_d = '0;
        per_d  = PER_W'(SLOW);
        ramp_d = '0;
      end else if (tick) begin
        if (ival_q == '0) begin
          step_d  = 1'b1;
          phase_d = mv_r ? phase_q + 2'd1 : phase_q - 2'd1;
          ival_d  = per_q - PER_W'(1);
          if (!accel_en) begin
            per_d  = PER_W'(SLOW);
            ramp_d = '0;
          end else if (ramp_q == RAMP_W'(RAMP - 1)) begin
            ramp_d = '0;
            per_d  = (per_q > PER_W'(FAST)) ? per_q - PER_W'(1) : PER_W'(FAST);
          end else begin
            ramp_d = ramp_q + RAMP_W'(1);
          end
        end else begin
          ival_d = ival_q - PER_W'(1);
        end
      end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
        phase_q  <= '0;
        ival_q   <= '0;
        per_q    <= PER_W'(SLOW);
        ramp_q   <= '0;
        last_r_q <= 1'b0;
        last_l_q <= 1'b0;
        steer_q  <= '0;
        strobe_q <= 1'b0;
      end else begin
        phase_q  <= phase_d;
        ival_q   <= ival_d;
        per_q    <= per_d;
        ramp_q   <= ramp_d;
        last_r_q <= mv_r;
        last_l_q <= mv_l;
        // Gray-coded {A,B}: index 0..3 -> 00,01,11,10.
        steer_q  <= {phase_d[1], phase_d[1] ^ phase_d[0]};
        strobe_q <= step_d;
      end
    end

    assign steer[2*g +: 2] = steer_q;
    assign step_strobe[g]  = strobe_q;
  end

endmodule

// File: tb/tb_multi_steer_quad.sv
// Bench for multi_steer_quad: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_multi_steer_quad;

  localparam int unsigned CH   = 2;
  localparam int unsigned DW   = 16;
  localparam int unsigned SLOW = 4;
  localparam int unsigned FAST = 1;
  localparam int unsigned RAMP = 2;

  logic          CLK = 1'b0;
  logic          Reset_n;
  logic [DW-1:0] clkdiv;
  logic          enable;
  logic          accel_en;
  logic [CH-1:0] left;
  logic [CH-1:0] right;
  logic [2*CH-1:0] steer;
  logic [CH-1:0] step_strobe;

  multi_steer_quad #(
    .CHANNELS(CH), .DIV_W(DW), .SLOW(SLOW), .FAST(FAST), .RAMP(RAMP)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .enable(enable),
    .accel_en(accel_en), .left(left), .right(right),
    .steer(steer), .step_strobe(step_strobe)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int s0_cnt;
  int s1_cnt;

  // Reference model: position on the quadrature wheel, ticks left to wait,
  // current step period, steps taken at that period, last direction.
  int m_pre;
  int m_pos  [CH];
  int m_wait [CH];
  int m_per  [CH];
  int m_done [CH];
  int m_last [CH];
  logic [CH-1:0] m_strobe;
  int enc [4] = '{0, 1, 3, 2};

  typedef struct {
    logic [DW-1:0] div;
    logic          en;
    logic          acc;
    logic [CH-1:0] l;
    logic [CH-1:0] r;
    int            cyc;
    logic [3:0]    exp_steer;
    int            exp_s0;
    int            exp_s1;
  } row_t;

  row_t rows [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = 0;
    m_strobe = '0;
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_wait[c] = 0; m_per[c] = int'(SLOW);
      m_done[c] = 0; m_last[c] = 0;
    end
  endtask

  task automatic model_tick();
    int  d;
    int  want;
    bit  tk;
    d  = (clkdiv == '0) ? 1 : int'(clkdiv);
    tk = enable && (m_pre >= d - 1);
    if (enable) m_pre = tk ? 0 : m_pre + 1;
    for (int c = 0; c < CH; c++) begin
      want = (right[c] && !left[c]) ? 1 : (left[c] && !right[c]) ? -1 : 0;
      m_strobe[c] = 1'b0;
      if (want == 0 || want == -m_last[c]) begin
        m_wait[c] = 0; m_per[c] = int'(SLOW); m_done[c] = 0;
      end else if (tk) begin
        if (m_wait[c] == 0) begin
          m_pos[c]    = (m_pos[c] + want + 4) % 4;
          m_strobe[c] = 1'b1;
          m_wait[c]   = m_per[c] - 1;
          if (accel_en) begin
            m_done[c]++;
            if (m_done[c] == int'(RAMP)) begin
              m_done[c] = 0;
              m_per[c]  = (m_per[c] - 1 > int'(FAST)) ? m_per[c] - 1 : int'(FAST);
            end
          end else begin
            m_per[c] = int'(SLOW); m_done[c] = 0;
          end
        end else begin
          m_wait[c]--;
        end
      end
      m_last[c] = want;
    end
  endtask

  function automatic logic [2*CH-1:0] model_steer();
    logic [2*CH-1:0] s;
    s = '0;
    for (int c = 0; c < CH; c++) s[2*c +: 2] = 2'(enc[m_pos[c]]);
    return s;
  endfunction

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic step_cycle();
    @(posedge CLK);
    if (!Reset_n) model_reset(); else model_tick();
    @(negedge CLK);
    check("steer", 32'(steer), 32'(model_steer()));
    check("strobe", 32'(step_strobe), 32'(m_strobe));
    s0_cnt += int'(step_strobe[0]);
    s1_cnt += int'(step_strobe[1]);
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    model_reset();
    step_cycle();
    step_cycle();
    Reset_n = 1'b1;
    s0_cnt = 0;
    s1_cnt = 0;
  endtask

  initial begin
    Reset_n = 1'b0; clkdiv = 16'd1; enable = 1'b1; accel_en = 1'b0;
    left = '0; right = '0; s0_cnt = 0; s1_cnt = 0;
    model_reset();

    rows[0] = '{16'd4, 1'b1, 1'b0, 2'b00, 2'b01, 68, 4'b0001, 5, 0};
    rows[1] = '{16'd4, 1'b1, 1'b0, 2'b00, 2'b01, 64, 4'b0000, 4, 0};
    rows[2] = '{16'd4, 1'b1, 1'b0, 2'b10, 2'b00, 36, 4'b0100, 0, 3};
    rows[3] = '{16'd4, 1'b1, 1'b0, 2'b01, 2'b01, 40, 4'b0000, 0, 0};
    rows[4] = '{16'd1, 1'b1, 1'b1, 2'b00, 2'b01, 22, 4'b0011, 10, 0};
    rows[5] = '{16'd0, 1'b1, 1'b0, 2'b00, 2'b11, 9,  4'b1010, 3, 3};
    rows[6] = '{16'd2, 1'b1, 1'b0, 2'b01, 2'b00, 18, 4'b0001, 3, 0};
    rows[7] = '{16'd1, 1'b0, 1'b0, 2'b00, 2'b01, 20, 4'b0000, 0, 0};

    @(negedge CLK);
    for (int k = 0; k < 8; k++) begin
      clkdiv = rows[k].div; enable = rows[k].en; accel_en = rows[k].acc;
      left = rows[k].l; right = rows[k].r;
      apply_reset();
      repeat (rows[k].cyc) step_cycle();
      check("row_steer", 32'(steer), 32'(rows[k].exp_steer));
      check("row_strobes0", 32'(s0_cnt), 32'(rows[k].exp_s0));
      check("row_strobes1", 32'(s1_cnt), 32'(rows[k].exp_s1));
    end

    // Reversal once the period has ramped to 2, then a frozen stretch.
    clkdiv = 16'd1; enable = 1'b1; accel_en = 1'b1; left = 2'b00; right = 2'b01;
    apply_reset();
    repeat (12) step_cycle();
    check("rev_pre_steer", 32'(steer), 32'h0);
    check("rev_pre_strobe", 32'(step_strobe), 32'h1);
    left = 2'b01; right = 2'b00;
    step_cycle();
    check("rev_flush_strobe", 32'(step_strobe), 32'h0);
    step_cycle();
    check("rev_first_steer", 32'(steer), 32'h2);
    check("rev_first_strobe", 32'(step_strobe), 32'h1);
    repeat (3) begin
      step_cycle();
      check("rev_gap_strobe", 32'(step_strobe), 32'h0);
    end
    step_cycle();
    check("rev_second_steer", 32'(steer), 32'h3);
    check("rev_second_strobe", 32'(step_strobe), 32'h1);
    enable = 1'b0;
    repeat (20) begin
      step_cycle();
      check("frozen_steer", 32'(steer), 32'h3);
      check("frozen_strobe", 32'(step_strobe), 32'h0);
    end
    enable = 1'b1;

    // Asynchronous reset at index 2, between clock edges.
    clkdiv = 16'd1; accel_en = 1'b0; left = 2'b00; right = 2'b01;
    apply_reset();
    repeat (6) step_cycle();
    check("async_pre_steer", 32'(steer), 32'h3);
    #2 Reset_n = 1'b0;
    #1;
    check("async_steer", 32'(steer), 32'h0);
    check("async_strobe", 32'(step_strobe), 32'h0);
    model_reset();
    step_cycle();
    step_cycle();
    Reset_n = 1'b1;
    step_cycle();
    check("async_resume_steer", 32'(steer), 32'h1);
    check("async_resume_strobe", 32'(step_strobe), 32'h1);

    // Randomized traffic with long holds so ramps develop.
    left = '0; right = '0; enable = 1'b1; clkdiv = 16'd1;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(15) == 0) right[c] = ~right[c];
        if ($urandom_range(23) == 0) left[c] = ~left[c];
      end
      if ($urandom_range(199) == 0) clkdiv = 16'($urandom_range(3));
      if (enable && $urandom_range(149) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(19) == 0) enable = 1'b1;
      if ($urandom_range(299) == 0) accel_en = ~accel_en;
      step_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
